// File: rtl/frame_udp_sender.sv
// Streams one SDRAM-buffered frame out as fixed-size UDP payloads.
// Words are popped from the read FIFO just in time and sent as bytes, least significant byte first.
module frame_udp_sender #(
    parameter int unsigned FRAME_WORDS     = 307200,
    parameter int unsigned PKT_BYTES       = 1024,
    parameter int unsigned PREFETCH_CYCLES = 64,
    parameter int unsigned IPG_CYCLES      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        read_req,
    input  logic        read_req_ack,
    output logic        read_en,
    input  logic [31:0] read_data,
    output logic        udp_tx_ready,
    input  logic        app_tx_data_request,
    output logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic [15:0] udp_data_length
);

    localparam logic [23:0] FRAME_W24     = 24'(FRAME_WORDS);
    localparam logic [23:0] PKT_WORDS     = 24'(PKT_BYTES / 4);
    localparam logic [15:0] PKT_LEN       = 16'(PKT_BYTES);
    localparam logic [31:0] PREFETCH_LAST = (PREFETCH_CYCLES > 0) ? 32'(PREFETCH_CYCLES - 1) : 32'd0;
    localparam logic [31:0] IPG_LAST      = (IPG_CYCLES > 0) ? 32'(IPG_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        PREFETCH,
        PKT_RDY,
        ACK,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t      state;
    logic [23:0] words_left;
    logic [15:0] byte_cnt;
    logic [31:0] wait_cnt;
    logic [23:0] byte_sr;
    logic        rd_vld_p1;
    logic [31:0] word_p2;
    logic [31:0] src_word;

    // Final packet is shortened to the words still left in the frame.
    function automatic logic [15:0] pkt_len(input logic [23:0] words);
        if (words < PKT_WORDS) begin
            return {words[13:0], 2'b00};
        end
        return PKT_LEN;
    endfunction

    // Stage p1 -> p2: FIFO word captured the cycle it is valid, held until its first byte slot.
    always_ff @(posedge clk) begin
        if (rd_vld_p1) begin
            word_p2 <= read_data;
        end
    end

    // Word 0 of a packet is needed the same cycle it arrives, so bypass the holding register.
    assign src_word = rd_vld_p1 ? read_data : word_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            read_req          <= 1'b0;
            read_en           <= 1'b0;
            udp_tx_ready      <= 1'b0;
            app_tx_ack        <= 1'b0;
            app_tx_data_valid <= 1'b0;
            app_tx_data       <= 8'h00;
            udp_data_length   <= 16'h0000;
            words_left        <= 24'h000000;
            byte_cnt          <= 16'h0000;
            wait_cnt          <= 32'h0;
            rd_vld_p1         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            app_tx_ack <= 1'b0;
            read_en    <= 1'b0;
            rd_vld_p1  <= read_en;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        busy       <= 1'b1;
                        read_req   <= 1'b1;
                        words_left <= FRAME_W24;
                    end
                end

                REQ: begin
                    if (read_req_ack) begin
                        read_req <= 1'b0;
                        wait_cnt <= 32'h0;
                        state    <= PREFETCH;
                    end
                end

                PREFETCH: begin
                    if (wait_cnt >= PREFETCH_LAST) begin
                        state           <= PKT_RDY;
                        udp_tx_ready    <= 1'b1;
                        udp_data_length <= pkt_len(words_left);
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                PKT_RDY: begin
                    if (app_tx_data_request) begin
                        state        <= ACK;
                        udp_tx_ready <= 1'b0;
                        app_tx_ack   <= 1'b1;
                        read_en      <= 1'b1;
                        words_left   <= words_left - 24'd1;
                        byte_cnt     <= 16'h0000;
                    end
                end

                ACK: begin
                    state <= SEND;
                end

                SEND: begin
                    if (byte_cnt < udp_data_length) begin
                        app_tx_data_valid <= 1'b1;
                        if (byte_cnt[1:0] == 2'b00) begin
                            app_tx_data <= src_word[7:0];
                            byte_sr     <= src_word[31:8];
                        end else begin
                            app_tx_data <= byte_sr[7:0];
                            byte_sr     <= {8'h00, byte_sr[23:8]};
                        end
                        // Pop the next word three bytes ahead of its first byte slot.
                        if (byte_cnt[1:0] == 2'b01 && (byte_cnt + 16'd3) < udp_data_length) begin
                            read_en    <= 1'b1;
                            words_left <= words_left - 24'd1;
                        end
                        byte_cnt <= byte_cnt + 16'd1;
                    end else begin
                        app_tx_data_valid <= 1'b0;
                        wait_cnt          <= 32'h0;
                        if (words_left == 24'd0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (wait_cnt >= IPG_LAST) begin
                        state           <= PKT_RDY;
                        udp_tx_ready    <= 1'b1;
                        udp_data_length <= pkt_len(words_left);
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
